// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and constants for the HEX display scheduler and its
// sequential binary-to-BCD converter.
package display_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int unsigned BCD_DIGITS_INT = 8;
  localparam int unsigned MAX_DEC        = 999999;
  localparam logic [1:0]  MODE_ROTATE    = 2'd3;

  // Double-dabble correction step: add 3 to every nibble that is 5 or more.
  function automatic logic [4*BCD_DIGITS_INT-1:0] dabble_adjust(
    input logic [4*BCD_DIGITS_INT-1:0] bcd
  );
    logic [4*BCD_DIGITS_INT-1:0] r;
    r = bcd;
    for (int unsigned d = 0; d < BCD_DIGITS_INT; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) r[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Constant-time conversion used to build the saturation pattern.
  function automatic logic [4*BCD_DIGITS_INT-1:0] dec_to_bcd(input int unsigned value);
    logic [4*BCD_DIGITS_INT-1:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int unsigned d = 0; d < BCD_DIGITS_INT; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one bit per clock, start pulse loads
// the operand, done is high during the final iteration cycle.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned DATA_W = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [DATA_W-1:0]             bin_in,
  output logic                          done,
  output logic [4*BCD_DIGITS_INT-1:0]   bcd
);

  logic [DATA_W-1:0]           bin_sr;
  logic [4:0]                  iter;
  logic                        running;
  logic [4*BCD_DIGITS_INT-1:0] bcd_adj;

  always_comb bcd_adj = dabble_adjust(bcd);

  assign done = running && (iter == 5'(DATA_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_sr  <= '0;
      bcd     <= '0;
      iter    <= '0;
      running <= 1'b0;
    end else if (start) begin
      bin_sr  <= bin_in;
      bcd     <= '0;
      iter    <= '0;
      running <= 1'b1;
    end else if (running) begin
      bcd    <= {bcd_adj[4*BCD_DIGITS_INT-2:0], bin_sr[DATA_W-1]};
      bin_sr <= {bin_sr[DATA_W-2:0], 1'b0};
      iter   <= iter + 5'd1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Time-shares the decimal HEX display between several binary sources,
// converting the selected word with a shared sequential BCD converter.
module hex_display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [1:0]                mode_sel,
  output logic [NUM_DIGITS*4-1:0]   digits,
  output logic                      digits_valid,
  output logic [1:0]                src_idx,
  output logic                      overflow,
  output logic                      busy
);

  localparam logic [4*BCD_DIGITS_INT-1:0] SAT_BCD = dec_to_bcd(MAX_DEC);

  state_t                      state, state_next;
  logic                        start_r;
  logic                        pending;
  logic [1:0]                  prev_idx;
  logic [1:0]                  rot_idx;
  logic [1:0]                  next_idx;
  logic [31:0]                 dwell;
  logic [DATA_W-1:0]           sel_data;
  logic                        sel_valid;
  logic                        trigger;
  logic                        load_en;
  logic                        done_en;
  logic                        conv_done;
  logic                        bcd_ovf;
  logic [4*BCD_DIGITS_INT-1:0] bcd;

  always_comb begin
    if (mode_sel == MODE_ROTATE)          next_idx = rot_idx;
    else if ({30'd0, mode_sel} < NUM_SRC) next_idx = mode_sel;
    else                                  next_idx = '0;
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (next_idx == 2'(i)) begin
        sel_data  = src_data[i*DATA_W +: DATA_W];
        sel_valid = src_valid[i];
      end
    end
  end

  // start_r fires one trigger on the first clock after reset release.
  assign trigger = sel_valid | (next_idx != prev_idx) | start_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_r  <= 1'b1;
      prev_idx <= '0;
      rot_idx  <= '0;
      dwell    <= '0;
    end else begin
      start_r  <= 1'b0;
      prev_idx <= next_idx;
      if (mode_sel != MODE_ROTATE) begin
        dwell <= '0;
      end else if (dwell == 32'(DWELL_CYCLES - 1)) begin
        dwell   <= '0;
        rot_idx <= (rot_idx == 2'(NUM_SRC - 1)) ? 2'd0 : rot_idx + 2'd1;
      end else begin
        dwell <= dwell + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (trigger || pending) state_next = LOAD;
      LOAD:  state_next = SHIFT;
      SHIFT: if (conv_done) state_next = DONE;
      DONE:  state_next = (pending || trigger) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_en = (state == LOAD);
    done_en = (state == DONE);
  end

  // A trigger seen while DONE is consumed directly by the DONE->LOAD arc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         pending <= 1'b0;
    else if (state == DONE)               pending <= 1'b0;
    else if (trigger && state != IDLE)    pending <= 1'b1;
  end

  bin2bcd_seq #(
    .DATA_W (DATA_W)
  ) u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (load_en),
    .bin_in  (sel_data),
    .done    (conv_done),
    .bcd     (bcd)
  );

  assign bcd_ovf = ((bcd >> (4*NUM_DIGITS)) != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits       <= '0;
      digits_valid <= 1'b0;
      src_idx      <= '0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (load_en) begin
        src_idx <= next_idx;
        busy    <= 1'b1;
      end
      if (done_en) begin
        busy         <= 1'b0;
        digits_valid <= 1'b1;
        overflow     <= bcd_ovf;
        digits       <= bcd_ovf ? SAT_BCD[NUM_DIGITS*4-1:0] : bcd[NUM_DIGITS*4-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler: latency, saturation, rotation,
// pending collapse and asynchronous reset.
module tb_hex_display_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [71:0] src_data;
  logic [2:0]  src_valid;
  logic [1:0]  mode_sel;
  logic [23:0] digits;
  logic        digits_valid;
  logic [1:0]  src_idx;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int base;

  always #5 clk = ~clk;

  hex_display_scheduler #(
    .NUM_SRC      (3),
    .DATA_W       (24),
    .NUM_DIGITS   (6),
    .DWELL_CYCLES (40)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .mode_sel     (mode_sel),
    .digits       (digits),
    .digits_valid (digits_valid),
    .src_idx      (src_idx),
    .overflow     (overflow),
    .busy         (busy)
  );

  always @(negedge busy) if (reset_n === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_src(input int i, input logic [23:0] v);
    src_data[i*24 +: 24] = v;
  endtask

  task automatic pulse(input int i, input logic [23:0] v);
    set_src(i, v);
    src_valid[i] = 1'b1;
    tick(1);
    src_valid = '0;
  endtask

  initial begin
    reset_n   = 1'b0;
    src_data  = '0;
    src_valid = '0;
    mode_sel  = 2'd0;
    tick(3);
    check("rst_digits", digits, 0);
    check("rst_valid", digits_valid, 0);
    check("rst_idx", src_idx, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);

    // Power-on auto conversion of source 0
    reset_n = 1'b1;
    tick(26);
    check("init_valid_early", digits_valid, 0);
    tick(1);
    check("init_valid", digits_valid, 1);
    check("init_digits", digits, 0);

    // Basic conversion with exact latency
    pulse(0, 24'd123456);
    tick(25);
    check("basic_busy_mid", busy, 1);
    check("basic_no_early", digits, 0);
    tick(1);
    check("basic_digits", digits, 32'h123456);
    check("basic_ovf", overflow, 0);
    check("basic_valid", digits_valid, 1);
    check("basic_busy", busy, 0);

    // Saturation via index change
    set_src(1, 24'd16777215);
    mode_sel = 2'd1;
    tick(27);
    check("sat_max_digits", digits, 32'h999999);
    check("sat_max_ovf", overflow, 1);
    check("sat_max_idx", src_idx, 1);
    pulse(1, 24'd1000000);
    tick(26);
    check("sat_1m_digits", digits, 32'h999999);
    check("sat_1m_ovf", overflow, 1);
    pulse(1, 24'd0);
    tick(26);
    check("zero_digits", digits, 0);
    check("zero_ovf", overflow, 0);

    // Edge values
    pulse(1, 24'd999999);
    tick(26);
    check("edge_999999", digits, 32'h999999);
    check("edge_999999_ovf", overflow, 0);
    pulse(1, 24'd9);
    tick(26);
    check("edge_9", digits, 32'h000009);

    // Pending collapse: two updates during SHIFT yield one re-conversion
    base = done_cnt;
    pulse(1, 24'd500);
    tick(10);
    pulse(1, 24'd600);
    tick(1);
    pulse(1, 24'd777);
    tick(12);
    check("pend_busy_mid", busy, 1);
    check("pend_no_early", digits, 32'h000009);
    tick(1);
    check("pend_first", digits, 32'h000500);
    tick(13);
    check("pend_hold", digits, 32'h000500);
    tick(12);
    check("pend_hold_late", digits, 32'h000500);
    check("pend_busy2", busy, 1);
    tick(1);
    check("pend_final", digits, 32'h000777);
    tick(30);
    check("pend_count", done_cnt - base, 2);
    check("pend_stable", digits, 32'h000777);
    check("pend_idle", busy, 0);

    // Auto-rotate with 40-cycle dwell
    set_src(0, 24'd11);
    set_src(1, 24'd22);
    set_src(2, 24'd33);
    mode_sel = 2'd3;
    tick(27);
    check("rot0_idx", src_idx, 0);
    check("rot0_digits", digits, 32'h11);
    tick(14);
    check("rot_idx_hold", src_idx, 0);
    tick(1);
    check("rot1_idx_load", src_idx, 1);
    tick(24);
    check("rot1_no_early", digits, 32'h11);
    tick(1);
    check("rot1_digits", digits, 32'h22);
    tick(40);
    check("rot2_idx", src_idx, 2);
    check("rot2_digits", digits, 32'h33);
    tick(40);
    check("rot3_idx", src_idx, 0);
    check("rot3_digits", digits, 32'h11);

    // Asynchronous reset mid-conversion
    mode_sel = 2'd2;
    tick(10);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_digits", digits, 0);
    check("arst_valid", digits_valid, 0);
    check("arst_idx", src_idx, 0);
    check("arst_ovf", overflow, 0);
    check("arst_busy", busy, 0);
    tick(2);
    reset_n = 1'b1;
    tick(26);
    check("rel_valid_early", digits_valid, 0);
    tick(1);
    check("rel_digits", digits, 32'h33);
    check("rel_valid", digits_valid, 1);
    check("rel_idx", src_idx, 2);
    check("rel_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
